// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache controller.
package dcache_miss_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dc_state_t;

  localparam int unsigned DC_CNT_W = 16;

  localparam logic [31:0] DC_SEG_BASE  = 32'h0000_0000;
  localparam logic [31:0] DC_SEG_LIMIT = 32'h0001_0000;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read, one registered write, synchronous valid clear.
module dcache_array #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_W    = 24
) (
  input  logic                clk,
  input  logic                i_clr,
  input  logic [IDX_BITS-1:0] i_ridx,
  output logic                o_rvalid,
  output logic [TAG_W-1:0]    o_rtag,
  output logic [31:0]         o_rdata,
  input  logic                i_we,
  input  logic [IDX_BITS-1:0] i_widx,
  input  logic [TAG_W-1:0]    i_wtag,
  input  logic [31:0]         i_wdata
);

  localparam int unsigned Lines = 1 << IDX_BITS;

  logic [Lines-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [Lines];
  logic [31:0]      r_data [Lines];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  // Tag and data contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_rvalid = r_valid[i_ridx];
  assign o_rtag   = r_tag[i_ridx];
  assign o_rdata  = r_data[i_ridx];

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with miss/segfault
// signalling for thread switching and refill-complete wake-up pulses.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int unsigned IDX_BITS  = 6,
  parameter logic [31:0] SEG_BASE  = DC_SEG_BASE,
  parameter logic [31:0] SEG_LIMIT = DC_SEG_LIMIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         d_addr,
  input  logic [31:0]         d_wr_data,
  input  logic                d_rd,
  input  logic                d_wr,
  input  logic [2:0]          d_trd,
  output logic [31:0]         d_rd_data,
  output logic                d_miss,
  output logic                d_segfault,
  output logic                m_req,
  output logic                m_we,
  output logic [31:0]         m_addr,
  output logic [31:0]         m_wdata,
  input  logic                m_ack,
  input  logic [31:0]         m_rdata,
  output logic                fill_done,
  output logic [2:0]          fill_trd,
  output logic [DC_CNT_W-1:0] hit_cnt,
  output logic [DC_CNT_W-1:0] miss_cnt
);

  localparam int unsigned TAG_W = 30 - IDX_BITS;

  dc_state_t r_state;

  logic                r_m_req;
  logic                r_m_we;
  logic [31:0]         r_m_addr;
  logic [31:0]         r_m_wdata;
  logic [2:0]          r_trd;
  logic                r_fill_done;
  logic [2:0]          r_fill_trd;
  logic [DC_CNT_W-1:0] r_hit_cnt;
  logic [DC_CNT_W-1:0] r_miss_cnt;

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_line_valid;
  logic [TAG_W-1:0]    w_line_tag;
  logic [31:0]         w_line_data;
  logic                w_hit;
  logic                w_bad_addr;
  logic                w_seg;
  logic                w_ld_hit;
  logic                w_ld_miss;
  logic                w_st_idle;
  logic                w_fill;
  logic                w_arr_we;
  logic [IDX_BITS-1:0] w_arr_idx;
  logic [TAG_W-1:0]    w_arr_tag;
  logic [31:0]         w_arr_data;

  assign w_idx = d_addr[IDX_BITS+1:2];
  assign w_tag = d_addr[31:IDX_BITS+2];
  assign w_hit = w_line_valid && (w_line_tag == w_tag);

  // Single unsigned compare covers both bounds: addresses below SEG_BASE wrap to large offsets.
  assign w_bad_addr = ((d_addr - SEG_BASE) >= (SEG_LIMIT - SEG_BASE)) || (d_addr[1:0] != 2'b00);
  assign w_seg      = ((d_rd || d_wr) && w_bad_addr) || (d_rd && d_wr);

  assign w_ld_hit  = d_rd && !w_seg && w_hit;
  assign w_ld_miss = d_rd && !w_seg && !w_hit;
  assign w_st_idle = d_wr && !w_seg && (r_state == IDLE);
  assign w_fill    = (r_state == RD) && m_ack;

  assign d_rd_data  = w_line_data;
  assign d_segfault = w_seg;
  assign d_miss     = w_ld_miss || (d_wr && !w_seg && (r_state != IDLE));

  // Refill and store-hit update are mutually exclusive: stores are only accepted in IDLE.
  always_comb begin
    w_arr_we   = 1'b0;
    w_arr_idx  = w_idx;
    w_arr_tag  = w_tag;
    w_arr_data = d_wr_data;
    if (w_fill) begin
      w_arr_we   = rst_n;
      w_arr_idx  = r_m_addr[IDX_BITS+1:2];
      w_arr_tag  = r_m_addr[31:IDX_BITS+2];
      w_arr_data = m_rdata;
    end else if (w_st_idle && w_hit) begin
      w_arr_we = rst_n;
    end
  end

  dcache_array #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk      (clk),
    .i_clr    (!rst_n),
    .i_ridx   (w_idx),
    .o_rvalid (w_line_valid),
    .o_rtag   (w_line_tag),
    .o_rdata  (w_line_data),
    .i_we     (w_arr_we),
    .i_widx   (w_arr_idx),
    .i_wtag   (w_arr_tag),
    .i_wdata  (w_arr_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_m_req     <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_trd       <= '0;
      r_fill_done <= 1'b0;
      r_fill_trd  <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_fill_done <= 1'b0;
      if (w_ld_hit && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + DC_CNT_W'(1);
      end
      if (w_ld_miss && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + DC_CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_ld_miss) begin
            r_state  <= RD;
            r_m_req  <= 1'b1;
            r_m_we   <= 1'b0;
            r_m_addr <= d_addr;
            r_trd    <= d_trd;
          end else if (w_st_idle) begin
            r_state   <= WR;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b1;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wr_data;
          end
        end
        RD: begin
          if (m_ack) begin
            r_state     <= IDLE;
            r_m_req     <= 1'b0;
            r_fill_done <= 1'b1;
            r_fill_trd  <= r_trd;
          end
        end
        WR: begin
          if (m_ack) begin
            r_state <= IDLE;
            r_m_req <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_m_req <= 1'b0;
        end
      endcase
    end
  end

  assign m_req     = r_m_req;
  assign m_we      = r_m_we;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign fill_done = r_fill_done;
  assign fill_trd  = r_fill_trd;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed self-checking bench for dcache_miss_ctrl with hand-computed expectations.
module tb_dcache_miss_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] d_addr;
  logic [31:0] d_wr_data;
  logic        d_rd;
  logic        d_wr;
  logic [2:0]  d_trd;
  logic [31:0] d_rd_data;
  logic        d_miss;
  logic        d_segfault;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        fill_done;
  logic [2:0]  fill_trd;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  dcache_miss_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_addr     (d_addr),
    .d_wr_data  (d_wr_data),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_trd      (d_trd),
    .d_rd_data  (d_rd_data),
    .d_miss     (d_miss),
    .d_segfault (d_segfault),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ack      (m_ack),
    .m_rdata    (m_rdata),
    .fill_done  (fill_done),
    .fill_trd   (fill_trd),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, " hit_cnt"}, {16'h0, hit_cnt}, exp_hit);
    chk({tag, " miss_cnt"}, {16'h0, miss_cnt}, exp_miss);
  endtask

  task automatic fill(input logic [31:0] addr, input logic [2:0] trd, input logic [31:0] data);
    d_rd = 1'b1; d_addr = addr; d_trd = trd;
    #1;
    chk("fill d_miss", {31'h0, d_miss}, 1);
    step();
    d_rd = 1'b0;
    exp_miss++;
    chk("fill m_req", {31'h0, m_req}, 1);
    chk("fill m_we", {31'h0, m_we}, 0);
    chk("fill m_addr", m_addr, addr);
    step();
    step();
    m_ack = 1'b1; m_rdata = data;
    step();
    m_ack = 1'b0; m_rdata = 32'h0;
    chk("fill fill_done", {31'h0, fill_done}, 1);
    chk("fill fill_trd", {29'h0, fill_trd}, {29'h0, trd});
    chk("fill m_req drop", {31'h0, m_req}, 0);
    step();
    chk("fill_done pulse", {31'h0, fill_done}, 0);
  endtask

  task automatic load_hit(input logic [31:0] addr, input logic [31:0] data);
    d_rd = 1'b1; d_addr = addr;
    #1;
    chk("hit d_miss", {31'h0, d_miss}, 0);
    chk("hit d_rd_data", d_rd_data, data);
    step();
    d_rd = 1'b0;
    exp_hit++;
    chk_cnt("hit");
  endtask

  task automatic seg(input string tag, input logic rd, input logic wr, input logic [31:0] addr);
    d_rd = rd; d_wr = wr; d_addr = addr; d_wr_data = 32'h5555_AAAA;
    #1;
    chk({tag, " d_segfault"}, {31'h0, d_segfault}, 1);
    step();
    d_rd = 1'b0; d_wr = 1'b0;
    chk({tag, " m_req"}, {31'h0, m_req}, 0);
    chk_cnt(tag);
  endtask

  initial begin
    rst_n = 1'b0; d_addr = '0; d_wr_data = '0; d_rd = 1'b0; d_wr = 1'b0; d_trd = '0;
    m_ack = 1'b0; m_rdata = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst m_req", {31'h0, m_req}, 0);
    chk("rst m_we", {31'h0, m_we}, 0);
    chk("rst m_addr", m_addr, 0);
    chk("rst m_wdata", m_wdata, 0);
    chk("rst fill_done", {31'h0, fill_done}, 0);
    chk("rst fill_trd", {29'h0, fill_trd}, 0);
    chk_cnt("rst");

    // First load misses, 5-cycle memory latency before m_ack.
    d_rd = 1'b1; d_addr = 32'h100; d_trd = 3'd2;
    #1;
    chk("ld100 d_miss", {31'h0, d_miss}, 1);
    chk("ld100 d_segfault", {31'h0, d_segfault}, 0);
    step();
    d_rd = 1'b0;
    exp_miss++;
    chk("ld100 m_req", {31'h0, m_req}, 1);
    chk("ld100 m_we", {31'h0, m_we}, 0);
    chk("ld100 m_addr", m_addr, 32'h100);
    chk_cnt("ld100");
    repeat (4) step();
    chk("ld100 m_req held", {31'h0, m_req}, 1);
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    step();
    m_ack = 1'b0; m_rdata = 32'h0;
    chk("ld100 fill_done", {31'h0, fill_done}, 1);
    chk("ld100 fill_trd", {29'h0, fill_trd}, 2);
    chk("ld100 m_req drop", {31'h0, m_req}, 0);
    step();
    chk("ld100 fill_done pulse", {31'h0, fill_done}, 0);
    load_hit(32'h100, 32'hDEAD_BEEF);

    // Store hit, then load during WR sees the new data.
    d_wr = 1'b1; d_addr = 32'h100; d_wr_data = 32'hCAFE_F00D;
    #1;
    chk("st100 d_miss", {31'h0, d_miss}, 0);
    step();
    d_wr = 1'b0;
    chk("st100 m_req", {31'h0, m_req}, 1);
    chk("st100 m_we", {31'h0, m_we}, 1);
    chk("st100 m_addr", m_addr, 32'h100);
    chk("st100 m_wdata", m_wdata, 32'hCAFE_F00D);
    chk_cnt("st100");
    load_hit(32'h100, 32'hCAFE_F00D);
    d_wr = 1'b1; d_addr = 32'h104; d_wr_data = 32'h1234_5678;
    #1;
    chk("st in WR d_miss", {31'h0, d_miss}, 1);
    step();
    d_wr = 1'b0;
    chk("st in WR m_wdata held", m_wdata, 32'hCAFE_F00D);
    chk_cnt("st in WR");
    m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
    step();
    m_ack = 1'b0;
    chk("wr ack m_req drop", {31'h0, m_req}, 0);
    chk("wr ack no fill_done", {31'h0, fill_done}, 0);

    // Accesses while a refill of 0x200 is outstanding (0x100/0x200/0x300 share index 0).
    d_rd = 1'b1; d_addr = 32'h200; d_trd = 3'd5;
    #1;
    chk("ld200 d_miss", {31'h0, d_miss}, 1);
    step();
    d_rd = 1'b0;
    exp_miss++;
    chk("ld200 m_addr", m_addr, 32'h200);
    load_hit(32'h100, 32'hCAFE_F00D);
    d_rd = 1'b1; d_addr = 32'h300;
    #1;
    chk("ld300 in RD d_miss", {31'h0, d_miss}, 1);
    step();
    d_rd = 1'b0;
    exp_miss++;
    chk("ld300 m_addr unchanged", m_addr, 32'h200);
    chk("ld300 m_req", {31'h0, m_req}, 1);
    chk_cnt("ld300");
    d_wr = 1'b1; d_addr = 32'h104;
    #1;
    chk("st104 in RD d_miss", {31'h0, d_miss}, 1);
    step();
    d_wr = 1'b0;
    chk_cnt("st104");
    d_rd = 1'b1; d_addr = 32'h200;
    #1;
    chk("ld200 in RD d_miss", {31'h0, d_miss}, 1);
    step();
    d_rd = 1'b0;
    exp_miss++;
    // Access in the m_ack cycle must see the pre-fill line.
    m_ack = 1'b1; m_rdata = 32'h2222_2222; d_rd = 1'b1; d_addr = 32'h100;
    #1;
    chk("ack cycle pre-fill hit", {31'h0, d_miss}, 0);
    chk("ack cycle pre-fill data", d_rd_data, 32'hCAFE_F00D);
    step();
    exp_hit++;
    m_ack = 1'b0; d_rd = 1'b0;
    chk("ld200 fill_done", {31'h0, fill_done}, 1);
    chk("ld200 fill_trd", {29'h0, fill_trd}, 5);
    chk_cnt("ld200");
    load_hit(32'h200, 32'h2222_2222);

    // Conflict misses on the shared index.
    fill(32'h100, 3'd1, 32'h1111_1111);
    load_hit(32'h100, 32'h1111_1111);
    fill(32'h200, 3'd3, 32'h3333_3333);
    fill(32'h100, 3'd4, 32'h4444_4444);

    // Segfaults: out of range, misaligned, simultaneous rd/wr; legal boundary word.
    seg("seg ld10000", 1'b1, 1'b0, 32'h0001_0000);
    seg("seg st102", 1'b0, 1'b1, 32'h0000_0102);
    seg("seg rdwr", 1'b1, 1'b1, 32'h0000_0100);
    d_rd = 1'b1; d_addr = 32'h0000_FFFC;
    #1;
    chk("limit-4 no segfault", {31'h0, d_segfault}, 0);
    d_rd = 1'b0;
    #1;

    // Saturation: 65536 consecutive hits.
    d_rd = 1'b1; d_addr = 32'h100;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sat hit_cnt", {16'h0, hit_cnt}, 32'h0000_FFFF);
    step();
    chk("sat hit_cnt hold", {16'h0, hit_cnt}, 32'h0000_FFFF);
    chk("sat miss_cnt", {16'h0, miss_cnt}, exp_miss);
    d_rd = 1'b0;

    // Reset while a refill is outstanding; an m_ack during reset is ignored.
    d_rd = 1'b1; d_addr = 32'h400; d_trd = 3'd6;
    step();
    d_rd = 1'b0;
    chk("ld400 m_req", {31'h0, m_req}, 1);
    rst_n = 1'b0; m_ack = 1'b1; m_rdata = 32'h6666_6666;
    step();
    chk("midrst m_req", {31'h0, m_req}, 0);
    rst_n = 1'b1;
    step();
    m_ack = 1'b0;
    chk("postrst fill_done", {31'h0, fill_done}, 0);
    chk("postrst m_req", {31'h0, m_req}, 0);
    exp_hit = 0; exp_miss = 0;
    chk_cnt("postrst");
    d_rd = 1'b1; d_addr = 32'h100;
    #1;
    chk("postrst ld100 d_miss", {31'h0, d_miss}, 1);
    d_rd = 1'b0;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
